// File: rtl/spi_pkg.sv
// Shared types for the SPI master frame sequencer: FSM state encoding and
// spi_mode status codes.
package spi_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StXfer,
        StFinish,
        StGap
    } spi_state_e;

    // spi_mode status codes
    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    // Decode of the CPU/enable state into the spi_mode status code
    function automatic logic [1:0] spi_mode_of(input logic spe, input logic wait_mode);
        if (!spe) begin
            return SPI_STOP;
        end else if (wait_mode) begin
            return SPI_WAIT;
        end
        return SPI_RUN;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Register-side bus of the SPI frame sequencer: transmit holding-buffer
// handshake, received word, and the SPIF status flag with its clear.
interface spi_xfer_ctrl_if #(
    parameter int unsigned DATA_W = 8
) ();
    import spi_pkg::*;

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              spif;
    logic              spif_clr;

    // Register block side
    modport master (
        output tx_valid, tx_data, spif_clr,
        input  tx_ready, rx_data, rx_valid, spif
    );

    // Frame sequencer side
    modport slave (
        input  tx_valid, tx_data, spif_clr,
        output tx_ready, rx_data, rx_valid, spif
    );

endinterface

// File: rtl/spi_shift_unit.sv
// Datapath of the SPI frame sequencer: tx/rx shift registers, launched-bit
// index and sampled-bit count. The tx word is stored in transmission order
// (bit 0 goes out first) so shifting never needs a variable bit index.
module spi_shift_unit
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              PClk,
    input  logic              PRESET,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              lsbfe_i,
    input  logic              sample_i,
    input  logic              shift_i,
    input  logic              miso_i,
    output logic              first_bit_o,
    output logic              advance_o,
    output logic              next_bit_o,
    output logic              last_sample_o,
    output logic [DATA_W-1:0] rx_word_o
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(DATA_W - 1);

    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [CntW-1:0]   tx_idx_q, tx_idx_d;
    logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic              lsbfe_q, lsbfe_d;
    logic [DATA_W-1:0] load_ord;
    logic [CntW-1:0]   rx_cnt_seen;

    // Reorder the buffer word and the received word between bit order and wire order
    always_comb begin
        load_ord  = '0;
        rx_word_o = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            load_ord[i]  = lsbfe_i ? load_data_i[i] : load_data_i[int'(DATA_W) - 1 - i];
            rx_word_o[i] = lsbfe_q ? rx_sr_q[i] : rx_sr_q[int'(DATA_W) - 1 - i];
        end
    end

    // A launch edge may only move past bits that have already been sampled; this
    // swallows the CPHA=1 leading edge and the trailing edge after the last sample.
    always_comb begin
        rx_cnt_seen   = rx_cnt_q + CntW'(sample_i);
        advance_o     = shift_i && (tx_idx_q < rx_cnt_seen) && (tx_idx_q < LastIdx);
        last_sample_o = sample_i && (rx_cnt_q == LastIdx);
        first_bit_o   = load_ord[0];
        next_bit_o    = tx_sr_q[1];
    end

    // Next-state of shift registers and counters
    always_comb begin
        tx_sr_d  = tx_sr_q;
        rx_sr_d  = rx_sr_q;
        tx_idx_d = tx_idx_q;
        rx_cnt_d = rx_cnt_q;
        lsbfe_d  = lsbfe_q;
        if (load_i) begin
            tx_sr_d  = load_ord;
            rx_sr_d  = '0;
            tx_idx_d = '0;
            rx_cnt_d = '0;
            lsbfe_d  = lsbfe_i;
        end else begin
            if (sample_i) begin
                // First received bit ends up in bit 0 after DATA_W samples
                rx_sr_d  = {miso_i, rx_sr_q[DATA_W-1:1]};
                rx_cnt_d = rx_cnt_seen;
            end
            if (advance_o) begin
                tx_sr_d  = tx_sr_q >> 1;
                tx_idx_d = tx_idx_q + CntW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) begin
            tx_sr_q  <= '0;
            rx_sr_q  <= '0;
            tx_idx_q <= '0;
            rx_cnt_q <= '0;
            lsbfe_q  <= 1'b0;
        end else begin
            tx_sr_q  <= tx_sr_d;
            rx_sr_q  <= rx_sr_d;
            tx_idx_q <= tx_idx_d;
            rx_cnt_q <= rx_cnt_d;
            lsbfe_q  <= lsbfe_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master frame sequencer. Takes words from the register side through a
// one-entry holding buffer, frames them with SS, shifts MOSI / captures MISO on
// the baud generator's launch/sample strobes and reports completion via
// rx_valid and the sticky SPIF flag.
// Build option: define SPI_BURST_EN to keep SS low and skip the inter-frame
// gap when the next word is already waiting at the end of a frame.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SS_GAP = 2
) (
    input  logic       PClk,
    input  logic       PRESET,
    input  logic       spe,
    input  logic       wait_mode,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic       shift_en,
    input  logic       sample_en,
    input  logic       miso,
    output logic       mosi,
    output logic       ss,
    output logic [1:0] spi_mode,
    spi_xfer_ctrl_if.slave bus
);

    // The LOAD cycle keeps SS high too, so GAP lasts SS_GAP-1 cycles and the
    // SS-high window between back-to-back frames is exactly SS_GAP cycles.
    localparam int unsigned GapW = $clog2(SS_GAP + 1);
    localparam int unsigned GapLastI = (SS_GAP >= 2) ? SS_GAP - 2 : 0;
    localparam logic [GapW-1:0] GapLast = GapW'(GapLastI);

    spi_state_e        state_q, state_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              spif_q, spif_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;

    logic              load_go, sample_go, shift_go;
    logic              first_bit, advance, next_bit, last_sample;
    logic [DATA_W-1:0] rx_word;
    logic              frame_done;
    logic              skip_gap;

    // Strobes only reach the datapath while a frame is in flight and enabled
    assign load_go   = spe && (state_q == StLoad);
    assign sample_go = spe && sample_en && (state_q == StXfer);
    assign shift_go  = spe && shift_en && (state_q == StXfer);

    spi_shift_unit #(
        .DATA_W (DATA_W)
    ) u_shift (
        .PClk          (PClk),
        .PRESET        (PRESET),
        .load_i        (load_go),
        .load_data_i   (buf_q),
        .lsbfe_i       (lsbfe),
        .sample_i      (sample_go),
        .shift_i       (shift_go),
        .miso_i        (miso),
        .first_bit_o   (first_bit),
        .advance_o     (advance),
        .next_bit_o    (next_bit),
        .last_sample_o (last_sample),
        .rx_word_o     (rx_word)
    );

    // Next-state of the sequencer, holding buffer and all registered outputs
    always_comb begin
        state_d    = state_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        mode_d     = spi_mode_of(spe, wait_mode);
        rx_data_d  = rx_data_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        gap_cnt_d  = gap_cnt_q;
        frame_done = 1'b0;
        skip_gap   = 1'b0;

        if (bus.tx_valid && !buf_full_q) begin
            buf_d      = bus.tx_data;
            buf_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                buf_full_d = 1'b0;
                ss_d       = 1'b0;
                mosi_d     = first_bit;
                state_d    = StXfer;
            end
            StXfer: begin
                if (advance) begin
                    mosi_d = next_bit;
                end
                if (last_sample) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                // CPHA=0 still owes the trailing edge that returns SCLK to idle
                if (cpha || shift_en) begin
                    frame_done = 1'b1;
`ifdef SPI_BURST_EN
                    skip_gap = buf_full_q;
`endif
                    if (skip_gap) begin
                        state_d = StLoad;
                    end else begin
                        ss_d      = 1'b1;
                        gap_cnt_d = '0;
                        if (SS_GAP == 1) begin
                            state_d = buf_full_q ? StLoad : StIdle;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + GapW'(1);
                if (gap_cnt_q == GapLast) begin
                    state_d = buf_full_q ? StLoad : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable aborts everything except the sticky flag
        if (!spe) begin
            state_d    = StIdle;
            ss_d       = 1'b1;
            mosi_d     = 1'b0;
            buf_full_d = 1'b0;
            frame_done = 1'b0;
        end

        rx_valid_d = frame_done;
        if (frame_done) begin
            rx_data_d = rx_word;
        end
        // Completion wins over a coincident clear
        spif_d = frame_done ? 1'b1 : (bus.spif_clr ? 1'b0 : spif_q);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge PClk or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= StIdle;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            mode_q     <= SPI_STOP;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            spif_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            mode_q     <= mode_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            spif_q     <= spif_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ss           = ss_q;
    assign mosi         = mosi_q;
    assign spi_mode     = mode_q;
    assign bus.tx_ready = ~buf_full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.spif     = spif_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: an emulated baud generator and SPI slave drive the
// strobes and MISO and capture MOSI; a scoreboard pairs every queued word with
// the frame the monitor sees complete.
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned GAP = 2;
    localparam int          DIV = 4;

    logic       PClk = 1'b0;
    logic       PRESET;
    logic       spe, wait_mode, cpha, lsbfe, shift_en, sample_en, miso;
    logic       mosi, ss;
    logic [1:0] spi_mode;

    spi_xfer_ctrl_if #(.DATA_W(W)) bus ();

    spi_xfer_ctrl #(
        .DATA_W (W),
        .SS_GAP (GAP)
    ) dut (
        .PClk      (PClk),
        .PRESET    (PRESET),
        .spe       (spe),
        .wait_mode (wait_mode),
        .cpha      (cpha),
        .lsbfe     (lsbfe),
        .shift_en  (shift_en),
        .sample_en (sample_en),
        .miso      (miso),
        .mosi      (mosi),
        .ss        (ss),
        .spi_mode  (spi_mode),
        .bus       (bus)
    );

    always #5 PClk = ~PClk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] slave_q[$];
    logic [W-1:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    // Baud generator and slave emulation
    int           edge_n = 0;
    int           div_n = 0;
    int           samp_in_frame = 0;
    int           idx;
    logic [W-1:0] cur_slave = '0;
    logic [W-1:0] cap = '0;
    bit           auto_clr = 0;
    bit           clr_req = 0;
    bit           clr_pend = 0;

    initial begin
        shift_en = 1'b0;
        sample_en = 1'b0;
        miso = 1'b0;
        bus.spif_clr = 1'b0;
        forever begin
            @(posedge PClk);
            #1;
            shift_en = 1'b0;
            sample_en = 1'b0;
            bus.spif_clr = 1'b0;
            if (clr_pend || clr_req) begin
                bus.spif_clr = 1'b1;
                clr_pend = 0;
                clr_req = 0;
            end
            if (ss !== 1'b0) begin
                edge_n = 0;
                div_n = 0;
                samp_in_frame = 0;
            end else begin
                div_n++;
                if (div_n == DIV) begin
                    div_n = 0;
                    // Leading edges are even; CPHA=0 samples on leading, CPHA=1 on trailing
                    if (((edge_n % 2) == 0) != (cpha == 1'b1)) begin
                        idx = (edge_n % (2 * W)) / 2;
                        if (idx == 0) begin
                            cur_slave = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
                        end
                        miso = lsbfe ? cur_slave[idx] : cur_slave[W-1-idx];
                        if (lsbfe) cap[idx] = mosi;
                        else cap[W-1-idx] = mosi;
                        sample_en = 1'b1;
                        samp_in_frame = idx + 1;
                        if (idx == W - 1) begin
                            got_q.push_back(cap);
                            if (cpha && auto_clr) clr_pend = 1;
                        end
                    end else begin
                        shift_en = 1'b1;
                    end
                    edge_n++;
                end
            end
        end
    end

    // Scoreboard monitor
    exp_t         mon_e;
    logic [W-1:0] mon_got;
    always @(negedge PClk) begin
        if (bus.rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_rx_valid");
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data", 32'(bus.rx_data), 32'(mon_e.rx));
                if (got_q.size() == 0) begin
                    timeout("mosi_frame_missing");
                end else begin
                    mon_got = got_q.pop_front();
                    check("mosi_word", 32'(mon_got), 32'(mon_e.tx));
                end
                check("spif_on_done", 32'(bus.spif), 32'd1);
            end
        end
    end

    // SS-high run tracking
    logic ss_prev = 1'b1;
    int   ss_falls = 0;
    int   hi_run = 0;
    int   last_hi_run = 0;
    always @(negedge PClk) begin
        if (ss === 1'b1) begin
            hi_run++;
        end else begin
            if (ss_prev === 1'b1) begin
                ss_falls++;
                last_hi_run = hi_run;
            end
            hi_run = 0;
        end
        ss_prev = ss;
    end

    task automatic put(input logic [W-1:0] t);
        int n = 0;
        while (bus.tx_ready !== 1'b1 && n < 2000) begin
            @(posedge PClk);
            #1;
            n++;
        end
        if (n >= 2000) timeout("tx_ready_wait");
        bus.tx_valid = 1'b1;
        bus.tx_data = t;
        @(posedge PClk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] t, input logic [W-1:0] s);
        exp_q.push_back('{tx: t, rx: s});
        slave_q.push_back(s);
        put(t);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || ss !== 1'b1) && n < 5000) begin
            @(posedge PClk);
            #1;
            n++;
        end
        if (n >= 5000) timeout("drain");
        repeat (4) begin
            @(posedge PClk);
            #1;
        end
    endtask

    int   falls0;
    int   n;
    logic spif_before;

    initial begin
        PRESET = 1'b1;
        spe = 1'b0;
        wait_mode = 1'b0;
        cpha = 1'b0;
        lsbfe = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(posedge PClk);
        #1;
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_spif", 32'(bus.spif), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_spi_mode", 32'(spi_mode), 32'(SPI_STOP));
        @(negedge PClk);
        PRESET = 1'b0;
        @(posedge PClk);
        #1;
        spe = 1'b1;
        @(posedge PClk);
        #1;
        check("mode_run", 32'(spi_mode), 32'(SPI_RUN));
        wait_mode = 1'b1;
        @(posedge PClk);
        #1;
        check("mode_wait", 32'(spi_mode), 32'(SPI_WAIT));
        wait_mode = 1'b0;
        @(posedge PClk);
        #1;
        check("mode_run2", 32'(spi_mode), 32'(SPI_RUN));

        // Directed MSB-first CPHA=0 frame
        send(8'hA5, 8'h3C);
        drain();
        check("a5_spif", 32'(bus.spif), 32'd1);
        check("a5_rx_data", 32'(bus.rx_data), 32'h3C);

        // CPHA=1, LSB first
        cpha = 1'b1;
        lsbfe = 1'b1;
        send(8'h81, 8'h6E);
        drain();

        // Second word during XFER accepted, third ignored
        cpha = 1'b0;
        lsbfe = 1'b0;
        falls0 = ss_falls;
        send(8'h5A, 8'hC3);
        n = 0;
        while (ss !== 1'b0 && n < 100) begin
            @(posedge PClk);
            #1;
            n++;
        end
        if (n >= 100) timeout("ss_fall_wait");
        check("tx_ready_in_xfer", 32'(bus.tx_ready), 32'd1);
        send(8'h96, 8'h0F);
        check("tx_ready_full", 32'(bus.tx_ready), 32'd0);
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hFF;
        @(posedge PClk);
        #1;
        bus.tx_valid = 1'b0;
        check("tx_ready_still_full", 32'(bus.tx_ready), 32'd0);
        drain();
        repeat (200) @(posedge PClk);
        #1;
`ifdef SPI_BURST_EN
        check("burst_ss_falls", 32'(ss_falls - falls0), 32'd1);
`else
        check("gap_ss_falls", 32'(ss_falls - falls0), 32'd2);
        check("gap_ss_high", 32'(last_hi_run), 32'(GAP));
`endif

        // Randomized frames
        for (int p = 0; p < 8; p++) begin
            cpha = 1'($urandom_range(0, 1));
            lsbfe = 1'($urandom_range(0, 1));
            for (int f = 0; f < int'($urandom_range(1, 4)); f++) begin
                send(W'($urandom()), W'($urandom()));
            end
            drain();
        end

        // Abort after three samples
        cpha = 1'b0;
        lsbfe = 1'b0;
        spif_before = bus.spif;
        slave_q.push_back(8'hE7);
        put(8'h3B);
        n = 0;
        @(posedge PClk);
        #2;
        while (samp_in_frame < 3 && n < 500) begin
            @(posedge PClk);
            #2;
            n++;
        end
        if (n >= 500) timeout("abort_sample_wait");
        @(posedge PClk);
        #1;
        spe = 1'b0;
        @(posedge PClk);
        #1;
        check("abort_ss", 32'(ss), 32'd1);
        check("abort_mode", 32'(spi_mode), 32'(SPI_STOP));
        check("abort_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("abort_spif", 32'(bus.spif), 32'(spif_before));
        repeat (50) @(posedge PClk);
        #1;
        check("abort_no_frame", 32'(got_q.size()), 32'd0);
        spe = 1'b1;

        // spif clear alone
        @(posedge PClk);
        #2;
        check("spif_before_clr", 32'(bus.spif), 32'd1);
        clr_req = 1;
        @(posedge PClk);
        @(posedge PClk);
        #2;
        check("spif_clr_alone", 32'(bus.spif), 32'd0);
        @(posedge PClk);
        #1;

        // Clear coincident with completion: set wins
        cpha = 1'b1;
        lsbfe = 1'b0;
        auto_clr = 1;
        send(8'hC9, 8'h24);
        drain();
        auto_clr = 0;
        check("spif_set_wins", 32'(bus.spif), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
